// File: rtl/spm_pkg.sv
// Shared definitions for the RISC SPM core: opcodes, FSM state encoding,
// register count and instruction field offsets (measured from the word MSB).
package spm_pkg;

    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;
    localparam int OPC_W     = 4;

    // Field LSB position expressed as distance below DATAWIDTH.
    localparam int OPC_OFS  = 4;
    localparam int SRC_OFS  = 6;
    localparam int DEST_OFS = 8;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_AND  = 4'h3;
    localparam opcode_t OP_NOT  = 4'h4;
    localparam opcode_t OP_RD   = 4'h5;
    localparam opcode_t OP_WR   = 4'h6;
    localparam opcode_t OP_BR   = 4'h7;
    localparam opcode_t OP_BRZ  = 4'h8;
    localparam opcode_t OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_ADDR,
        S_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/spm_alu.sv
// Combinational ALU for the SPM core: ADD/SUB/AND/NOT with a zero flag.
module spm_alu
    import spm_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [OPC_W-1:0]     op,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] result,
    output logic                 zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_NOT:  result = ~b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/risc_spm_core.sv
// Multi-cycle 4-register SPM processor with a req/ack memory port.
// Define SPM_ILLEGAL_TRAP_EN to trap opcodes 9-E (err=1, halt); otherwise they run as NOP.
module risc_spm_core
    import spm_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 halted,
    output logic                 err,
    output logic                 zero,
    output logic [ADDRWIDTH-1:0] dbg_pc,
    input  logic [1:0]           dbg_sel,
    output logic [DATAWIDTH-1:0] dbg_data
);

    state_t                 state_reg;
    logic [DATAWIDTH-1:0]   regs_reg [NUM_REGS];
    logic [ADDRWIDTH-1:0]   pc_reg;
    logic [ADDRWIDTH-1:0]   opnd_reg;
    logic [DATAWIDTH-1:0]   ir_reg;
    logic                   zero_reg;
    logic                   err_reg;

    opcode_t                opcode;
    logic [REG_IDX_W-1:0]   src;
    logic [REG_IDX_W-1:0]   dest;
    logic [DATAWIDTH-1:0]   alu_result;
    logic                   alu_zero;

    assign opcode = ir_reg[DATAWIDTH-1 -: OPC_W];
    assign src    = ir_reg[DATAWIDTH-OPC_OFS-1 -: REG_IDX_W];
    assign dest   = ir_reg[DATAWIDTH-SRC_OFS-1 -: REG_IDX_W];

    spm_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .op     (opcode),
        .a      (regs_reg[dest]),
        .b      (regs_reg[src]),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Memory port is a pure decode of registered state, so ack never loops back to req.
    assign mem_req   = (state_reg == S_FETCH) || (state_reg == S_ADDR) || (state_reg == S_MEM);
    assign mem_we    = (state_reg == S_MEM) && (opcode == OP_WR);
    assign mem_addr  = (state_reg == S_MEM) ? opnd_reg : pc_reg;
    assign mem_wdata = regs_reg[src];
    assign halted    = (state_reg == S_HALT);
    assign err       = err_reg;
    assign zero      = zero_reg;
    assign dbg_pc    = pc_reg;
    assign dbg_data  = regs_reg[dbg_sel];

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= S_RST;
            pc_reg    <= '0;
            opnd_reg  <= '0;
            ir_reg    <= '0;
            zero_reg  <= 1'b0;
            err_reg   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                S_RST: state_reg <= S_FETCH;

                S_FETCH: begin
                    if (mem_ack) begin
                        ir_reg    <= mem_rdata;
                        pc_reg    <= pc_reg + 1'b1;
                        state_reg <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (opcode)
                        OP_NOP: state_reg <= S_FETCH;
                        OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                            regs_reg[dest] <= alu_result;
                            zero_reg       <= alu_zero;
                            state_reg      <= S_FETCH;
                        end
                        OP_RD, OP_WR, OP_BR, OP_BRZ: state_reg <= S_ADDR;
                        OP_HALT: state_reg <= S_HALT;
                        default: begin
`ifdef SPM_ILLEGAL_TRAP_EN
                            err_reg   <= 1'b1;
                            state_reg <= S_HALT;
`else
                            state_reg <= S_FETCH;
`endif
                        end
                    endcase
                end

                S_ADDR: begin
                    if (mem_ack) begin
                        opnd_reg <= mem_rdata[ADDRWIDTH-1:0];
                        // A taken branch overrides the post-operand increment.
                        if ((opcode == OP_BR) || ((opcode == OP_BRZ) && zero_reg)) begin
                            pc_reg <= mem_rdata[ADDRWIDTH-1:0];
                        end else begin
                            pc_reg <= pc_reg + 1'b1;
                        end
                        if ((opcode == OP_RD) || (opcode == OP_WR)) begin
                            state_reg <= S_MEM;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        if (opcode == OP_RD) begin
                            regs_reg[dest] <= mem_rdata;
                        end
                        state_reg <= S_FETCH;
                    end
                end

                S_HALT: state_reg <= S_HALT;

                default: state_reg <= S_RST;
            endcase
        end
    end

endmodule
